// File: rtl/img_edge_detector_top.sv
// 5x5 grayscale Laplacian edge detector: input frame buffer, one-pixel-per-cycle
// kernel sweep in raster order, rectified/clipped output frame buffer with 1-cycle read port.

module img_frame_buf_in #(
   parameter int IMG_W   = 5,
   parameter int IMG_H   = 5,
   parameter int PXL_W   = 8,
   parameter int COORD_W = 3
) (
   input  logic               clk,
   input  logic               wr_en_i,
   input  logic               wr_block_i,
   input  logic [COORD_W-1:0] wr_x_i,
   input  logic [COORD_W-1:0] wr_y_i,
   input  logic [PXL_W-1:0]   wr_data_pxl_i,
   output logic [PXL_W-1:0]   img_o [IMG_H][IMG_W]
);
   localparam logic [COORD_W-1:0] X_LIM = COORD_W'(IMG_W);
   localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(IMG_H);

   logic [PXL_W-1:0] img_buf [IMG_H][IMG_W];

   // Contents deliberately survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_en_i && !wr_block_i && (wr_x_i < X_LIM) && (wr_y_i < Y_LIM))
         img_buf[wr_y_i][wr_x_i] <= wr_data_pxl_i;
   end

   assign img_o = img_buf;
endmodule

module img_frame_buf_out #(
   parameter int IMG_W   = 5,
   parameter int IMG_H   = 5,
   parameter int PXL_W   = 8,
   parameter int COORD_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en_i,
   input  logic [COORD_W-1:0] wr_x_i,
   input  logic [COORD_W-1:0] wr_y_i,
   input  logic [PXL_W-1:0]   wr_data_pxl_i,
   input  logic               rd_en_i,
   input  logic [COORD_W-1:0] rd_x_i,
   input  logic [COORD_W-1:0] rd_y_i,
   output logic [PXL_W-1:0]   rd_data_pxl_o
);
   localparam logic [COORD_W-1:0] X_LIM = COORD_W'(IMG_W);
   localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(IMG_H);

   logic [PXL_W-1:0] img_buf [IMG_H][IMG_W];
   logic [PXL_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i && (wr_x_i < X_LIM) && (wr_y_i < Y_LIM))
         img_buf[wr_y_i][wr_x_i] <= wr_data_pxl_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         if ((rd_x_i < X_LIM) && (rd_y_i < Y_LIM)) rd_data_q <= img_buf[rd_y_i][rd_x_i];
         else                                        rd_data_q <= '0;
      end
   end

   assign rd_data_pxl_o = rd_data_q;
endmodule

module img_edge_detector_top #(
   parameter int IMG_W   = 5,
   parameter int IMG_H   = 5,
   parameter int PXL_W   = 8,
   parameter int COORD_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   output logic               done,
   input  logic               frame_buf_in_wr_en,
   input  logic [COORD_W-1:0] frame_buf_in_wr_x,
   input  logic [COORD_W-1:0] frame_buf_in_wr_y,
   input  logic [PXL_W-1:0]   frame_buf_in_wr_data_pxl,
   input  logic               frame_buf_out_rd_en,
   input  logic [COORD_W-1:0] frame_buf_out_rd_x,
   input  logic [COORD_W-1:0] frame_buf_out_rd_y,
   output logic [PXL_W-1:0]   frame_buf_out_rd_data_pxl
);
   // state | meaning
   // IDLE  | waiting for run
   // PROC  | one output pixel per cycle at (x_q, y_q)
   // DONE  | frame complete, done high until run drops
   typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

   localparam int SUM_W = PXL_W + 3;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

   state_t             state_q;
   logic [COORD_W-1:0] x_q, y_q;
   logic               done_q;

   logic [PXL_W-1:0]        img_in [IMG_H][IMG_W];
   logic signed [SUM_W-1:0] p_c, p_l, p_r, p_u, p_d, sum, mag;
   logic [PXL_W-1:0]        pix_d;

   img_frame_buf_in #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PXL_W(PXL_W), .COORD_W(COORD_W)) frame_buf_in (
      .clk           (clk),
      .wr_en_i       (frame_buf_in_wr_en),
      .wr_block_i    (state_q == PROC),
      .wr_x_i        (frame_buf_in_wr_x),
      .wr_y_i        (frame_buf_in_wr_y),
      .wr_data_pxl_i (frame_buf_in_wr_data_pxl),
      .img_o         (img_in)
   );

   // Zero padding: neighbours outside the frame contribute nothing.
   always_comb begin
      p_c = SUM_W'(img_in[y_q][x_q]);
      p_l = (x_q == '0)     ? '0 : SUM_W'(img_in[y_q][x_q - 1'b1]);
      p_r = (x_q == X_LAST) ? '0 : SUM_W'(img_in[y_q][x_q + 1'b1]);
      p_u = (y_q == '0)     ? '0 : SUM_W'(img_in[y_q - 1'b1][x_q]);
      p_d = (y_q == Y_LAST) ? '0 : SUM_W'(img_in[y_q + 1'b1][x_q]);
      sum = (p_c <<< 2) - p_l - p_r - p_u - p_d;
      mag = sum[SUM_W-1] ? -sum : sum;
      pix_d = (mag > SUM_W'(2**PXL_W - 1)) ? '1 : mag[PXL_W-1:0];
   end

   img_frame_buf_out #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PXL_W(PXL_W), .COORD_W(COORD_W)) frame_buf_rectify_clip (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en_i       (state_q == PROC),
      .wr_x_i        (x_q),
      .wr_y_i        (y_q),
      .wr_data_pxl_i (pix_d),
      .rd_en_i       (frame_buf_out_rd_en),
      .rd_x_i        (frame_buf_out_rd_x),
      .rd_y_i        (frame_buf_out_rd_y),
      .rd_data_pxl_o (frame_buf_out_rd_data_pxl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (run) begin
               state_q <= PROC;
               x_q     <= '0;
               y_q     <= '0;
            end
            PROC: if (x_q == X_LAST) begin
               x_q <= '0;
               if (y_q == Y_LAST) begin
                  y_q     <= '0;
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  y_q <= y_q + 1'b1;
               end
            end else begin
               x_q <= x_q + 1'b1;
            end
            DONE: if (!run) begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign done = done_q;
endmodule

// File: tb/tb_img_edge_detector_top.sv
// Self-checking bench for img_edge_detector_top against an arithmetic
// Laplacian/rectify/clip model of the frame.

module tb_img_edge_detector_top;
   localparam int W = 5;
   localparam int H = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       done;
   logic       wr_en = 1'b0;
   logic [2:0] wr_x = '0, wr_y = '0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic [2:0] rd_x = '0, rd_y = '0;
   logic [7:0] rd_data;

   int checks = 0;
   int errors = 0;
   int in_m [H][W];
   int got  [H][W];

   always #5 clk = ~clk;

   img_edge_detector_top dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .run                       (run),
      .done                      (done),
      .frame_buf_in_wr_en        (wr_en),
      .frame_buf_in_wr_x         (wr_x),
      .frame_buf_in_wr_y         (wr_y),
      .frame_buf_in_wr_data_pxl  (wr_data),
      .frame_buf_out_rd_en       (rd_en),
      .frame_buf_out_rd_x        (rd_x),
      .frame_buf_out_rd_y        (rd_y),
      .frame_buf_out_rd_data_pxl (rd_data)
   );

   function automatic int pix(int x, int y);
      if (x < 0 || y < 0 || x >= W || y >= H) return 0;
      return in_m[y][x];
   endfunction

   function automatic int ref_out(int x, int y);
      int s;
      s = 4 * pix(x, y) - pix(x - 1, y) - pix(x + 1, y) - pix(x, y - 1) - pix(x, y + 1);
      if (s < 0) s = -s;
      return (s > 255) ? 255 : s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(int x, int y, int v);
      wr_en = 1'b1; wr_x = 3'(x); wr_y = 3'(y); wr_data = 8'(v);
      step();
      wr_en = 1'b0;
      if (x < W && y < H) in_m[y][x] = v;
   endtask

   task automatic rd(int x, int y, output int v);
      rd_en = 1'b1; rd_x = 3'(x); rd_y = 3'(y);
      step();
      rd_en = 1'b0;
      v = int'(rd_data);
   endtask

   task automatic read_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) rd(x, y, got[y][x]);
   endtask

   task automatic do_run(output int lat);
      run = 1'b1;
      lat = 0;
      while (done !== 1'b1 && lat < 60) begin
         step();
         lat++;
      end
   endtask

   task automatic run_frame(string name);
      int lat;
      do_run(lat);
      checks++;
      if (lat != 26 || done !== 1'b1) begin
         errors++;
         $display("FAIL %s_latency got %0d cycles done=%b, expected 26 cycles done=1", name, lat, done);
      end
      run = 1'b0;
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_drop got %b expected 0", name, done);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (done !== 1'b0 || rd_data !== 8'd0) begin
         errors++;
         $display("FAIL reset_values got done=%b rd=%0d expected done=0 rd=0", done, rd_data);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_diagonal();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) wr(x, y, (x == y) ? 250 + x : 0);
      rst_n = 1'b0;
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL diag_reset_done got %b expected 0", done);
      end
      rst_n = 1'b1;
      run_frame("diag");
      read_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            int exp_v;
            exp_v = (x == y || x - y == 1 || y - x == 1) ? 255 : 0;
            checks++;
            if (got[y][x] != exp_v || got[y][x] != ref_out(x, y)) begin
               errors++;
               $display("FAIL diag_pixel(%0d,%0d) got %0d expected %0d", x, y, got[y][x], exp_v);
            end
         end
   endtask

   task automatic test_uniform();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) wr(x, y, 100);
      run_frame("uniform");
      read_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            int nb;
            nb = (x == 0 || x == W - 1 ? 1 : 0) + (y == 0 || y == H - 1 ? 1 : 0);
            checks++;
            if (got[y][x] != nb * 100 || got[y][x] != ref_out(x, y)) begin
               errors++;
               $display("FAIL uniform_pixel(%0d,%0d) got %0d expected %0d", x, y, got[y][x], nb * 100);
            end
         end
   endtask

   task automatic test_out_of_range();
      int v;
      rd(0, 0, v);
      rd_x = 3'd3; rd_y = 3'd3;
      step();
      checks++;
      if (rd_data !== 8'd200) begin
         errors++;
         $display("FAIL rd_hold got %0d expected 200", rd_data);
      end
      rd(5, 0, v);
      checks++;
      if (v != 0) begin
         errors++;
         $display("FAIL oor_read_x got %0d expected 0", v);
      end
      rd(0, 0, v);
      rd(0, 6, v);
      checks++;
      if (v != 0) begin
         errors++;
         $display("FAIL oor_read_y got %0d expected 0", v);
      end
      wr(5, 1, 7);
      wr(1, 7, 9);
      wr(7, 4, 3);
      run_frame("oor");
      read_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            checks++;
            if (got[y][x] != ref_out(x, y)) begin
               errors++;
               $display("FAIL oor_frame(%0d,%0d) got %0d expected %0d", x, y, got[y][x], ref_out(x, y));
            end
         end
   endtask

   task automatic test_single_pixel();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) wr(x, y, 0);
      wr(2, 2, 10);
      run_frame("single");
      read_frame();
      checks++;
      if (got[2][2] != 40) begin
         errors++;
         $display("FAIL single_center got %0d expected 40", got[2][2]);
      end
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            checks++;
            if (got[y][x] != ref_out(x, y)) begin
               errors++;
               $display("FAIL single_pixel(%0d,%0d) got %0d expected %0d", x, y, got[y][x], ref_out(x, y));
            end
         end
   endtask

   task automatic test_hold_run();
      int lat, v, old_c;
      bit held;
      old_c = ref_out(2, 2);
      do_run(lat);
      checks++;
      if (lat != 26) begin
         errors++;
         $display("FAIL hold_first_latency got %0d expected 26", lat);
      end
      wr(2, 2, 77);
      held = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done !== 1'b1) held = 1'b0;
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL hold_done got dropped expected steady 1");
      end
      rd(2, 2, v);
      checks++;
      if (v != old_c) begin
         errors++;
         $display("FAIL hold_no_rewrite got %0d expected %0d", v, old_c);
      end
      run = 1'b0;
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL hold_drop got %b expected 0", done);
      end
      run_frame("rerun");
      read_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            checks++;
            if (got[y][x] != ref_out(x, y)) begin
               errors++;
               $display("FAIL rerun_pixel(%0d,%0d) got %0d expected %0d", x, y, got[y][x], ref_out(x, y));
            end
         end
   endtask

   task automatic test_reset_mid_proc();
      int lat;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) wr(x, y, int'($urandom_range(0, 255)));
      run = 1'b1;
      for (int i = 0; i < 4; i++) step();
      wr_en = 1'b1; wr_x = 3'd1; wr_y = 3'd1; wr_data = 8'(in_m[1][1] ^ 8'h5a);
      step();
      wr_en = 1'b0;
      for (int i = 0; i < 5; i++) step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (done !== 1'b0 || rd_data !== 8'd0) begin
         errors++;
         $display("FAIL midproc_reset got done=%b rd=%0d expected 0 0", done, rd_data);
      end
      step();
      step();
      rst_n = 1'b1;
      do_run(lat);
      checks++;
      if (lat != 26 || done !== 1'b1) begin
         errors++;
         $display("FAIL midproc_restart_latency got %0d expected 26", lat);
      end
      run = 1'b0;
      step();
      read_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            checks++;
            if (got[y][x] != ref_out(x, y)) begin
               errors++;
               $display("FAIL midproc_pixel(%0d,%0d) got %0d expected %0d", x, y, got[y][x], ref_out(x, y));
            end
         end
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         int maxv;
         maxv = (f % 2 == 0) ? 255 : 40;
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) wr(x, y, int'($urandom_range(0, maxv)));
         run_frame("random");
         read_frame();
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
               checks++;
               if (got[y][x] != ref_out(x, y)) begin
                  errors++;
                  $display("FAIL random%0d_pixel(%0d,%0d) got %0d expected %0d",
                           f, x, y, got[y][x], ref_out(x, y));
               end
            end
      end
   endtask

   initial begin
      test_reset();
      test_diagonal();
      test_uniform();
      test_out_of_range();
      test_single_pixel();
      test_hold_run();
      test_reset_mid_proc();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
